// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG collector.
package trng_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_COLLECT, ST_FAIL} trng_state_e;

    localparam int DEF_WORD_W        = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_WARMUP_CYCLES = 256;
    localparam int DEF_REP_LIMIT     = 32;
endpackage

// File: rtl/trng_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; pushes while full are ignored.
module trng_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wptr_q, rptr_q;
    logic [AW:0]                 level_q;
    logic                        do_push, do_pop;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up discard, repetition-count health test, word assembly, FIFO.
// Define TRNG_VN_DEBIAS_EN to enable von Neumann debiasing of the raw stream.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            trng_en,
    input  logic                            trng_out,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [WORD_W-1:0]               rd_data,
    output logic                            health_fail,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int WC_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int BC_W  = $clog2(WORD_W);

    trng_state_e       state_q, state_d;
    logic              trng_en_q;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              prev_q, prev_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic              pend_q, pend_d;
    logic              bit_vld, bit_val, push, fifo_full;
`ifdef TRNG_VN_DEBIAS_EN
    logic              pair_vld_q, pair_vld_d, pair_bit_q, pair_bit_d;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        run_d   = run_q;
        prev_d  = prev_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        pend_d  = pend_q;
        bit_vld = 1'b0;
        bit_val = trng_out;
`ifdef TRNG_VN_DEBIAS_EN
        pair_vld_d = pair_vld_q;
        pair_bit_d = pair_bit_q;
`endif
        // A completed word waits in the shift register until the FIFO has room.
        push = pend_q && !fifo_full;
        if (push) pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WARMUP;
                    wcnt_d  = '0;
                end
            end
            ST_WARMUP: begin
                if (!enable)                                 state_d = ST_IDLE;
                else if (wcnt_q == WC_W'(WARMUP_CYCLES - 1)) state_d = ST_COLLECT;
                else                                         wcnt_d  = wcnt_q + WC_W'(1);
            end
            ST_COLLECT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    run_d  = (run_q == '0 || trng_out != prev_q) ? RUN_W'(1) : run_q + RUN_W'(1);
                    prev_d = trng_out;
                    if (run_d == RUN_W'(REP_LIMIT)) begin
                        state_d = ST_FAIL;
                    end else begin
`ifdef TRNG_VN_DEBIAS_EN
                        if (pair_vld_q) begin
                            pair_vld_d = 1'b0;
                            bit_vld    = (trng_out != pair_bit_q);
                            bit_val    = pair_bit_q;
                        end else begin
                            pair_vld_d = 1'b1;
                            pair_bit_d = trng_out;
                        end
`else
                        bit_vld = 1'b1;
`endif
                    end
                end
            end
            ST_FAIL: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bits arriving while a held word is still blocked are dropped.
        if (bit_vld && (!pend_q || push)) begin
            shift_d = {shift_q[WORD_W-2:0], bit_val};
            if (bcnt_q == BC_W'(WORD_W - 1)) begin
                bcnt_d = '0;
                pend_d = 1'b1;
            end else begin
                bcnt_d = bcnt_q + BC_W'(1);
            end
        end

        if (state_d != ST_COLLECT) begin
            run_d   = '0;
            prev_d  = 1'b0;
            shift_d = '0;
            bcnt_d  = '0;
            pend_d  = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld_d = 1'b0;
            pair_bit_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            trng_en_q <= 1'b0;
            wcnt_q    <= '0;
            run_q     <= '0;
            prev_q    <= 1'b0;
            shift_q   <= '0;
            bcnt_q    <= '0;
            pend_q    <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            trng_en_q <= (state_d == ST_WARMUP) || (state_d == ST_COLLECT);
            wcnt_q    <= wcnt_d;
            run_q     <= run_d;
            prev_q    <= prev_d;
            shift_q   <= shift_d;
            bcnt_q    <= bcnt_d;
            pend_q    <= pend_d;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld_q <= pair_vld_d;
            pair_bit_q <= pair_bit_d;
`endif
        end
    end

    assign trng_en     = trng_en_q;
    assign health_fail = (state_q == ST_FAIL);

    trng_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_ready),
        .rdata_o (rd_data),
        .valid_o (rd_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );
endmodule

// File: tb/tb_trng_collector.sv
// Randomised scoreboard bench for trng_collector with a behavioural reference model.
module tb_trng_collector;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int WARM   = 4;
    localparam int LIMIT  = 32;
`ifdef TRNG_VN_DEBIAS_EN
    localparam int          RAW_PER_BIT = 2;
    localparam logic [31:0] FIRST_WORD  = 32'hFFFF_FFFF;
`else
    localparam int          RAW_PER_BIT = 1;
    localparam logic [31:0] FIRST_WORD  = 32'hAAAA_AAAA;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, trng_out = 1'b0, rd_ready = 1'b0;
    logic        trng_en, rd_valid, health_fail;
    logic [31:0] rd_data;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    trng_collector #(
        .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARM), .REP_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trng_en(trng_en), .trng_out(trng_out),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .health_fail(health_fail), .fifo_level(fifo_level)
    );

    int vectors = 0, errors = 0;
    bit mon_en = 1'b0;

    // Reference model: 0 idle, 1 warm-up, 2 collect, 3 failed.
    int          m_state = 0, m_wc = 0, m_run = 0, m_n = 0, m_level = 0;
    bit          m_prev = 0, m_ten = 0, m_hold_v = 0, m_pair_have = 0, m_pair_first = 0;
    logic [31:0] m_cur = 0, m_hold = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit pop, push, use_bit, b;
        if (reset) begin
            m_state = 0; m_ten = 0; m_level = 0; exp_q.delete();
            m_wc = 0; m_run = 0; m_prev = 0; m_n = 0; m_cur = 0;
            m_hold_v = 0; m_pair_have = 0; m_pair_first = 0;
            return;
        end
        pop  = (m_level != 0) && rd_ready;
        push = m_hold_v && (m_level != DEPTH);
        if (push) begin
            exp_q.push_back(m_hold);
            m_hold_v = 0;
        end
        m_level = m_level + int'(push) - int'(pop);
        use_bit = 0;
        b = trng_out;
        case (m_state)
            0: if (enable) begin m_state = 1; m_wc = 0; end
            1: if (!enable) m_state = 0; else if (m_wc == WARM - 1) m_state = 2; else m_wc++;
            2: begin
                if (!enable) m_state = 0;
                else begin
                    m_run  = (m_run == 0 || trng_out != m_prev) ? 1 : m_run + 1;
                    m_prev = trng_out;
                    if (m_run >= LIMIT) m_state = 3;
                    else begin
`ifdef TRNG_VN_DEBIAS_EN
                        if (m_pair_have) begin
                            m_pair_have = 0;
                            if (trng_out != m_pair_first) begin use_bit = 1; b = m_pair_first; end
                        end else begin
                            m_pair_have  = 1;
                            m_pair_first = trng_out;
                        end
`else
                        use_bit = 1;
`endif
                    end
                end
            end
            3: if (!enable) m_state = 0;
            default: m_state = 0;
        endcase
        if (use_bit && !m_hold_v) begin
            m_cur = m_cur * 2 + 32'(b);
            m_n++;
            if (m_n == WORD_W) begin m_hold = m_cur; m_hold_v = 1; m_n = 0; end
        end
        if (m_state != 2) begin
            m_run = 0; m_n = 0; m_cur = 0; m_hold_v = 0; m_pair_have = 0;
        end
        m_ten = (m_state == 1) || (m_state == 2);
    endtask

    task automatic cyc(input bit rst, input bit en, input bit s, input bit rdy);
        reset = rst; enable = en; trng_out = s; rd_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: checks control outputs every cycle and consumes words as the DUT offers them.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("trng_en", trng_en, m_ten);
            chk("health_fail", health_fail, m_state == 3);
            chk("fifo_level", fifo_level, m_level);
            chk("rd_valid", rd_valid, m_level != 0);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL rd_data_unexpected: got %0h with no word expected", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q[0]);
                    if (rd_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int t_en, t_vld, guard;
        bit ph, done, en_r, stuck, r;
        int mode;

        cyc(1, 0, 0, 0);
        mon_en = 1'b1;
        cyc(1, 0, 0, 0);
        chk("rst_trng_en", trng_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_health", health_fail, 0);
        chk("rst_level", fifo_level, 0);

        // Alternating stream, first collected sample is 1; no reads until five words exist.
        t_en = -1; t_vld = -1; ph = 0;
        for (int k = 0; k < 5 * WORD_W * RAW_PER_BIT + 24; k++) begin
            cyc(0, 1, k[0], 0);
            if (trng_en && t_en < 0) t_en = k;
            if (rd_valid && t_vld < 0) begin
                t_vld = k;
                chk("first_word", rd_data, FIRST_WORD);
            end
            ph = !k[0];
        end
        chk("en_latency", t_en, 0);
        chk("valid_latency", t_vld - t_en, WARM + WORD_W * RAW_PER_BIT + 1);
        chk("full_level", fifo_level, 4);
        cyc(0, 1, ph, 1); ph = !ph;
        chk("level_after_pop", fifo_level, 3);
        cyc(0, 1, ph, 0); ph = !ph;
        chk("level_refill", fifo_level, 4);

        // Stuck-at-1 source must trip the repetition test.
        for (int k = 0; k < 40; k++) cyc(0, 1, 1, 0);
        chk("fail_flag", health_fail, 1);
        chk("fail_trng_en", trng_en, 0);
        cyc(0, 0, 1, 0);
        chk("fail_clear", health_fail, 0);
        chk("fail_level_kept", fifo_level, 4);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
        chk("drained", fifo_level, 0);

        // Pop exactly on the cycle a push lands at level 2.
        done = 0; guard = 0; ph = 0;
        while (!done && guard < 600) begin
            r = (m_level == 2) && m_hold_v;
            cyc(0, 1, ph, r); ph = !ph;
            if (r) begin chk("pushpop_level", fifo_level, 2); done = 1; end
            guard++;
        end
        if (!done) begin vectors++; errors++; $display("FAIL pushpop_timeout: level %0d", fifo_level); end

        // Reset in the middle of a word with three words buffered.
        done = 0; guard = 0;
        while (!done && guard < 600) begin
            cyc(0, 1, ph, 0); ph = !ph;
            done = (m_level == 3) && (m_n > 0);
            guard++;
        end
        if (!done) begin vectors++; errors++; $display("FAIL midreset_timeout: level %0d", fifo_level); end
        cyc(1, 1, ph, 0);
        chk("mid_rst_trng_en", trng_en, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_health", health_fail, 0);
        chk("mid_rst_level", fifo_level, 0);

        // Random traffic with stuck-source bursts, enable drops and rare resets.
        en_r = 1; stuck = 0; mode = 1;
        for (int k = 0; k < 4000; k++) begin
            if (k % 150 == 0) begin mode = $urandom_range(0, 3); stuck = 1'($urandom_range(0, 1)); end
            if (en_r && $urandom_range(0, 299) == 0) en_r = 0;
            else if (!en_r && $urandom_range(0, 9) == 0) en_r = 1;
            if (m_state == 3 && $urandom_range(0, 29) == 0) en_r = 0;
            cyc($urandom_range(0, 1999) == 0, en_r,
                (mode == 0) ? stuck : 1'($urandom_range(0, 1)),
                (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
        chk("final_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/trng_collector.md
# trng_collector

Consumer side of the ring-oscillator TRNG: samples the TRNG's serial `trng_out` bit stream on `clk`, drives the TRNG's `trng_en`, applies a warm-up discard and a repetition-count health test, assembles bits into words, and buffers them in a small FIFO. The FIFO is read through a valid/ready port by the SoC bus peripheral.

## Interface
- `WORD_W`, 32: output word width in bits.
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `WARMUP_CYCLES`, 256: raw samples discarded after enable, at least 1.
- `REP_LIMIT`, 32: number of consecutive identical raw samples that declares failure, at least 2.

Ports:
- `clk`  in  1: sampling and system clock, shared with the TRNG.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: software enable for collection.
- `trng_en`  out  1: drives the TRNG `trng_en`.
- `trng_out`  in  1: serial raw bit from the TRNG, already in the `clk` domain.
- `rd_valid`  out  1: FIFO head word available.
- `rd_ready`  in  1: consumer accepts the head word.
- `rd_data`  out  `WORD_W`: FIFO head word.
- `health_fail`  out  1: sticky health-test failure.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`: number of words in the FIFO.

## Operation
- FSM states: IDLE, WARMUP, COLLECT, FAIL.
  - IDLE: `trng_en`=0. Goes to WARMUP when `enable`=1.
  - WARMUP: `trng_en`=1. The warm-up counter counts `WARMUP_CYCLES` cycles and all samples are discarded. Then goes to COLLECT.
  - COLLECT: `trng_en`=1. Each cycle, `trng_out` is one raw sample.
  - FAIL: `trng_en`=0 and `health_fail`=1.
- Any state except FAIL goes to IDLE when `enable`=0. FAIL goes to IDLE only when `enable`=0, which also clears `health_fail`.
- Leaving COLLECT discards the partial word and debias pair state. FIFO contents are kept and stay readable in every state.
- Health test (COLLECT only): a run counter counts consecutive equal raw samples and resets to 1 on a change. When the counter reaches `REP_LIMIT`, the FSM goes to FAIL on the next edge. The sample that triggered failure is not used.
- Word assembly: each accepted bit shifts in at the LSB (`word <= {word[WORD_W-2:0], bit}`). After `WORD_W` accepted bits, the word is pushed and the bit counter wraps to 0.
- FIFO full when a word completes: the completed word is held and further accepted bits are dropped until a slot frees. The held word is pushed in the first cycle the FIFO is not full.
- FIFO: push is allowed only if not full, using the registered level. Pop happens when `rd_valid && rd_ready`. Simultaneous push and pop with 0 < level < `FIFO_DEPTH` leaves the level unchanged. When full, a pop and a pending push in the same cycle: the pop completes and the push waits one cycle.
- `rd_valid` = (level != 0). `rd_data` is the head word (show-ahead) and is stable while `rd_valid && !rd_ready`.

## Timing
- Reset values: FSM=IDLE, `trng_en`=0, `rd_valid`=0, `rd_data`=0, `health_fail`=0, `fifo_level`=0. All counters and the shift register are 0.
- `trng_en` is registered. It rises one cycle after `enable` is sampled high and falls one cycle after `enable` is sampled low or a failure is detected.
- Samples are used starting `WARMUP_CYCLES` cycles after `trng_en` rises.
- Push to `rd_valid`: `rd_valid` rises the cycle after the push edge.
- Minimum word period: `WORD_W` cycles without debias, `2*WORD_W` cycles or more with debias.
- Reset during any operation takes effect at the next edge and overrides all other inputs.

## Configuration
- `TRNG_VN_DEBIAS_EN` defined: von Neumann debiasing. Raw samples are paired; pairs start at the first COLLECT sample.
  - Pair 01 gives bit 0, pair 10 gives bit 1.
  - Pairs 00 and 11 are discarded.
  - The health test still sees every raw sample.
- `TRNG_VN_DEBIAS_EN` undefined: every raw sample in COLLECT is an accepted bit.

## Structure
- `trng_pkg`: FSM state enum (`trng_state_e`) and default parameter constants.
- Sub-module `trng_fifo`: a synchronous show-ahead FIFO parameterised by width and depth, with level output and the same clock and reset.
- The FSM, health counter, debias logic and shift register live in `trng_collector`.

## Test plan
- Reset, then `enable`=1 with `WARMUP_CYCLES`=4, debias off, alternating bits starting with 1 → `trng_en` rises 1 cycle after `enable`. The first word is 0xAAAAAAAA and `rd_valid` rises 4+32+1 cycles after `trng_en` rises.
- Debias on, raw stream 10,01,11,00 repeated → accepted bits are 1,0 per repeat, and the first word is 0xAAAAAAAA after 128 raw samples.
- `trng_out` held at 1 in COLLECT, `REP_LIMIT`=32 → FAIL entered, `trng_en`=0, `health_fail`=1. Dropping `enable` returns to IDLE with `health_fail`=0 and FIFO contents intact.
- `rd_ready`=0 until 5 words complete with `FIFO_DEPTH`=4 → `fifo_level`=4. The 5th word is held and its bits are frozen. Pop one word → the held word is pushed the following cycle and the level returns to 4.
- Simultaneous push and pop at level 2 → level stays 2 and the FIFO stays in order.
- Assert `reset` mid-word with level 3 → all outputs return to reset values on the next edge.
